// File: rtl/bcd_entry_to_binary_pkg.sv
// Shared definitions for the two-digit decimal entry path.
// Holds the state encoding, BCD limits and the width of the decoded decimal value.
package bcd_entry_to_binary_pkg;

    localparam int ST_W    = 3;
    localparam int BCD_MAX = 9;
    localparam int DEC_W   = 7;

    localparam logic [ST_W-1:0] S_EMPTY = 3'd0;
    localparam logic [ST_W-1:0] S_ONE   = 3'd1;
    localparam logic [ST_W-1:0] S_TWO   = 3'd2;
    localparam logic [ST_W-1:0] S_CONV  = 3'd3;
    localparam logic [ST_W-1:0] S_HOLD  = 3'd4;
    localparam logic [ST_W-1:0] S_ERR   = 3'd5;

    typedef enum logic [ST_W-1:0] {
        ST_EMPTY = S_EMPTY,
        ST_ONE   = S_ONE,
        ST_TWO   = S_TWO,
        ST_CONV  = S_CONV,
        ST_HOLD  = S_HOLD,
        ST_ERR   = S_ERR
    } state_t;

    function automatic logic is_bcd(input logic [3:0] d);
        return d <= 4'(BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_entry_to_binary_bcd2.sv
// Two BCD digits to binary: tens*10 + ones, built as (t<<3)+(t<<1)+o.
// Inputs are assumed to be valid BCD, so the result never exceeds 99.
module bcd2_to_bin
    import bcd_entry_to_binary_pkg::*;
(
    input  logic [3:0]       i_tens,
    input  logic [3:0]       i_ones,
    output logic [DEC_W-1:0] o_value
);

    logic [DEC_W-1:0] w_tens;
    logic [DEC_W-1:0] w_ones;

    assign w_tens  = DEC_W'(i_tens);
    assign w_ones  = DEC_W'(i_ones);
    assign o_value = (w_tens << 3) + (w_tens << 1) + w_ones;

endmodule

// File: rtl/bcd_entry_to_binary.sv
// Keypad-style decimal entry: shifts in up to two BCD digits, converts on enter,
// and delivers the binary operand over a valid/ready handshake.
module bcd_entry_to_binary
    import bcd_entry_to_binary_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_VALUE = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       digit_in,
    input  logic             digit_stb,
    input  logic             enter_stb,
    input  logic             clear_stb,
    output logic [3:0]       d_tens,
    output logic [3:0]       d_ones,
    output logic [WIDTH-1:0] operand,
    output logic             operand_valid,
    input  logic             operand_ready,
    output logic             err
);

    state_t           r_state;
    logic [3:0]       r_tens;
    logic [3:0]       r_ones;
    logic [WIDTH-1:0] r_operand;
    logic             r_valid;
    logic             r_err;

    state_t           w_state_nx;
    logic [3:0]       w_tens_nx;
    logic [3:0]       w_ones_nx;
    logic [WIDTH-1:0] w_operand_nx;
    logic             w_valid_nx;
    logic             w_err_nx;
    logic [DEC_W-1:0] w_value;
    logic             w_in_range;

    bcd2_to_bin u_bcd2_to_bin (
        .i_tens  (r_tens),
        .i_ones  (r_ones),
        .o_value (w_value)
    );

    assign w_in_range = (w_value <= DEC_W'(MAX_VALUE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_EMPTY;
            r_tens    <= '0;
            r_ones    <= '0;
            r_operand <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_tens    <= w_tens_nx;
            r_ones    <= w_ones_nx;
            r_operand <= w_operand_nx;
            r_valid   <= w_valid_nx;
            r_err     <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_tens_nx    = r_tens;
        w_ones_nx    = r_ones;
        w_operand_nx = r_operand;
        w_valid_nx   = r_valid;
        w_err_nx     = r_err;

        // HOLD is checked before clear: an offered operand is never withdrawn.
        if (r_state == ST_HOLD) begin
            if (operand_ready && r_valid) begin
                w_valid_nx = 1'b0;
                w_tens_nx  = '0;
                w_ones_nx  = '0;
                w_state_nx = ST_EMPTY;
            end
        end else if (clear_stb) begin
            w_tens_nx  = '0;
            w_ones_nx  = '0;
            w_err_nx   = 1'b0;
            w_state_nx = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY, ST_ONE, ST_TWO: begin
                    // Enter wins over a simultaneous digit; the digit is dropped.
                    if (enter_stb && r_state != ST_EMPTY) begin
                        w_state_nx = ST_CONV;
                    end else if (digit_stb) begin
                        if (is_bcd(digit_in)) begin
                            w_tens_nx  = r_ones;
                            w_ones_nx  = digit_in;
                            w_state_nx = (r_state == ST_EMPTY) ? ST_ONE : ST_TWO;
                        end else begin
                            w_err_nx   = 1'b1;
                            w_state_nx = ST_ERR;
                        end
                    end
                end
                ST_CONV: begin
                    if (w_in_range) begin
                        w_operand_nx = WIDTH'(w_value);
                        w_valid_nx   = 1'b1;
                        w_state_nx   = ST_HOLD;
                    end else begin
                        w_err_nx   = 1'b1;
                        w_state_nx = ST_ERR;
                    end
                end
                ST_ERR: begin
                    w_err_nx = 1'b1;
                end
                default: begin
                    w_state_nx = ST_EMPTY;
                end
            endcase
        end
    end

    assign d_tens        = r_tens;
    assign d_ones        = r_ones;
    assign operand       = r_operand;
    assign operand_valid = r_valid;
    assign err           = r_err;

endmodule

// File: tb/tb_bcd_entry_to_binary.sv
// Randomized and directed bench with a queue-of-digits reference model and an operand scoreboard.
module tb_bcd_entry_to_binary;

    localparam int WIDTH = 4;
    localparam int MAXV  = 15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       digit_in = '0;
    logic             digit_stb = 1'b0;
    logic             enter_stb = 1'b0;
    logic             clear_stb = 1'b0;
    logic             operand_ready = 1'b0;
    logic [3:0]       d_tens;
    logic [3:0]       d_ones;
    logic [WIDTH-1:0] operand;
    logic             operand_valid;
    logic             err;

    bcd_entry_to_binary #(.WIDTH(WIDTH), .MAX_VALUE(MAXV)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .digit_in      (digit_in),
        .digit_stb     (digit_stb),
        .enter_stb     (enter_stb),
        .clear_stb     (clear_stb),
        .d_tens        (d_tens),
        .d_ones        (d_ones),
        .operand       (operand),
        .operand_valid (operand_valid),
        .operand_ready (operand_ready),
        .err           (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: entered digits as a list, a coarse phase, and the offered operand.
    int dq[$];
    int sb[$];
    int m_phase = 0; // 0 entering, 1 converting, 2 offering, 3 error
    int m_err = 0;
    int m_valid = 0;
    int m_operand = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_tens();
        return (dq.size() == 2) ? dq[0] : 0;
    endfunction

    function automatic int m_ones();
        return (dq.size() > 0) ? dq[dq.size()-1] : 0;
    endfunction

    task automatic model_reset();
        dq.delete();
        sb.delete();
        m_phase = 0; m_err = 0; m_valid = 0; m_operand = 0;
    endtask

    task automatic model_step(input bit c, input bit e, input bit d, input int di, input bit r);
        int v;
        if (m_phase == 2) begin
            if (r) begin
                m_valid = 0; dq.delete(); m_phase = 0;
            end
        end else if (c) begin
            dq.delete(); m_err = 0; m_phase = 0;
        end else if (m_phase == 0) begin
            if (e && dq.size() > 0) m_phase = 1;
            else if (d) begin
                if (di <= 9) begin
                    dq.push_back(di);
                    if (dq.size() > 2) void'(dq.pop_front());
                end else begin
                    m_phase = 3; m_err = 1;
                end
            end
        end else if (m_phase == 1) begin
            v = m_tens() * 10 + m_ones();
            if (v > MAXV) begin
                m_phase = 3; m_err = 1;
            end else begin
                m_operand = v; m_valid = 1; m_phase = 2;
                sb.push_back(v);
            end
        end
    endtask

    task automatic cycle(input bit c, input bit e, input bit d, input int di, input bit r);
        clear_stb = c; enter_stb = e; digit_stb = d; digit_in = 4'(di); operand_ready = r;
        @(posedge clk);
        #1;
        model_step(c, e, d, di, r);
        clear_stb = 0; enter_stb = 0; digit_stb = 0;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        rst_n = 1'b0;
        clear_stb = 0; enter_stb = 0; digit_stb = 0; digit_in = 0; operand_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_d_tens", d_tens, 0);
        chk("rst_d_ones", d_ones, 0);
        chk("rst_operand", operand, 0);
        chk("rst_valid", operand_valid, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        mon_en = 1'b1;
    endtask

    // Monitor: cycle-by-cycle outputs against the model, operands against the scoreboard.
    initial begin
        int exp;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("mon_d_tens", d_tens, m_tens());
                chk("mon_d_ones", d_ones, m_ones());
                chk("mon_err", err, m_err);
                chk("mon_valid", operand_valid, m_valid);
                chk("mon_operand", operand, m_operand);
                if (operand_valid && operand_ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        exp = sb.pop_front();
                        chk("sb_operand", operand, exp);
                    end
                end
            end
        end
    end

    initial begin
        do_reset();

        // 1,2 enter: valid two cycles after enter, operand 12, digits cleared after transfer.
        cycle(0, 0, 1, 1, 1);
        cycle(0, 0, 1, 2, 1);
        cycle(0, 1, 0, 0, 1);
        chk("lat_conv_low", operand_valid, 0);
        operand_ready = 0;
        cycle(0, 0, 0, 0, 0);
        chk("lat_valid_high", operand_valid, 1);
        chk("op12", operand, 12);
        cycle(0, 0, 0, 0, 1);
        chk("after_xfer_valid", operand_valid, 0);
        chk("after_xfer_tens", d_tens, 0);
        chk("after_xfer_ones", d_ones, 0);

        // Single digit 7 with backpressure for five cycles.
        cycle(0, 0, 1, 7, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, 0);
            chk("stall_valid", operand_valid, 1);
            chk("stall_op7", operand, 7);
        end
        cycle(1, 0, 1, 3, 0); // clear and digit ignored in HOLD
        chk("hold_clear_ignored", operand_valid, 1);
        cycle(0, 0, 0, 0, 1);
        chk("stall_release", operand_valid, 0);

        // 16 is out of range: error, no operand; clear recovers.
        cycle(0, 0, 1, 1, 1);
        cycle(0, 0, 1, 6, 1);
        cycle(0, 1, 0, 0, 1);
        repeat (3) cycle(0, 0, 0, 0, 1);
        chk("range_err", err, 1);
        chk("range_no_valid", operand_valid, 0);
        cycle(1, 0, 0, 0, 0);
        chk("clear_err", err, 0);
        chk("clear_ones", d_ones, 0);

        // Non-BCD digit: error immediately, digits frozen until clear.
        cycle(0, 0, 1, 2, 0);
        cycle(0, 0, 1, 4'hB, 0);
        chk("bad_digit_err", err, 1);
        chk("bad_digit_ones", d_ones, 2);
        cycle(0, 0, 1, 3, 0);
        chk("err_digit_ignored", d_ones, 2);
        cycle(1, 0, 0, 0, 0);

        // Three strokes keep the last two; enter with a digit converts the old value.
        cycle(0, 0, 1, 9, 0);
        cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 5, 0);
        chk("shift_tens", d_tens, 1);
        chk("shift_ones", d_ones, 5);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("op15", operand, 15);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 1, 3, 0);
        cycle(0, 1, 1, 8, 0);
        cycle(0, 0, 0, 0, 0);
        chk("enter_beats_digit", operand, 3);
        cycle(0, 0, 0, 0, 1);

        // Asynchronous reset while offering an operand.
        cycle(0, 0, 1, 5, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("pre_rst_valid", operand_valid, 1);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_valid", operand_valid, 0);
        chk("async_operand", operand, 0);
        chk("async_err", err, 0);
        do_reset();

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            bit c, e, d, r;
            int di;
            c  = ($urandom_range(0, 99) < 3);
            e  = ($urandom_range(0, 99) < 15);
            d  = ($urandom_range(0, 99) < 45);
            r  = ($urandom_range(0, 99) < 50);
            di = ($urandom_range(0, 99) < 88) ? int'($urandom_range(0, 9)) : int'($urandom_range(10, 15));
            cycle(c, e, d, di, r);
        end
        cycle(0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_entry_to_binary.md
Name: bcd_entry_to_binary

Overview:
Input-side counterpart of the adder/display path. It accepts decimal digits one at a time from a digit source (keypad or switch bank plus strobe) and assembles a two-digit decimal number. On an enter strobe it converts the number to a WIDTH-bit binary operand for four_bit_adder. It also echoes the digits entered so far for the seven-segment display, and flags invalid digits or out-of-range values.

Parameters:
WIDTH, 4, width of the binary operand delivered downstream.
MAX_VALUE, 15, largest legal decimal value; must be ≤ 2^WIDTH-1 and ≤ 99.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
digit_in  input  4  BCD digit to shift in; sampled only when digit_stb=1.
digit_stb  input  1  single-cycle strobe, digit_in valid.
enter_stb  input  1  single-cycle strobe, finish entry and convert.
clear_stb  input  1  single-cycle strobe, abort entry and clear error.
d_tens  output  4  echoed tens digit for display.
d_ones  output  4  echoed ones digit for display.
operand  output  WIDTH  converted binary value; stable while operand_valid=1.
operand_valid  output  1  operand available (valid/ready handshake).
operand_ready  input  1  downstream accepts operand.
err  output  1  sticky error: bad digit or value > MAX_VALUE.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n). While rst_n=0: state=EMPTY, d_tens=0, d_ones=0, operand=0, operand_valid=0, err=0. Reset mid-conversion or mid-handshake drops operand_valid at once, with no completion.
- FSM states: EMPTY, ONE, TWO, CONV, HOLD, ERR.
- Digit accept, only in EMPTY, ONE or TWO. If digit_stb=1 and digit_in≤9: d_tens←d_ones, d_ones←digit_in. State advances EMPTY→ONE→TWO. In TWO, a further digit shifts again (oldest digit lost) and the state stays TWO.
- Digit >9 (A–F) with digit_stb=1, in EMPTY/ONE/TWO: go to ERR, set err=1, digits unchanged.
- enter_stb in EMPTY: ignored. In ONE or TWO: go to CONV.
- CONV, one cycle: value = d_tens*10 + d_ones, computed 7 bits wide (max 99). If value > MAX_VALUE: go to ERR with err=1. Otherwise: operand ← value[WIDTH-1:0], operand_valid=1 from the next cycle, go to HOLD.
- Latency: operand_valid rises 2 cycles after the cycle in which enter_stb is sampled.
- HOLD: operand and operand_valid are held until operand_ready=1 is sampled with operand_valid=1. On that edge: operand_valid←0, d_tens←0, d_ones←0, go to EMPTY. operand keeps its last value. digit_stb and enter_stb are ignored in HOLD and CONV.
- ERR: all strobes except clear_stb are ignored. err stays 1.
- clear_stb, any state except HOLD: digits←0, err←0, go to EMPTY. In HOLD, clear_stb is ignored (a transfer is never withdrawn).
- Priority within one cycle: clear_stb > enter_stb > digit_stb. If enter_stb and digit_stb arrive together in ONE or TWO, the digit is dropped and the value before the digit is converted.
- operand_ready with operand_valid=0 has no effect.

Decomposition:
- Shared package holds: state encoding localparams (EMPTY..ERR, 3 bits), BCD_MAX=9, DEC_W=7 (width of the two-digit value).
- One natural sub-module: bcd2_to_bin. It is purely combinational (tens*10 + ones as shift-add: (t<<3)+(t<<1)+o) and is the inverse of the existing binary_to_decimal block. The FSM, digit registers and handshake stay in the top.

Test Plan:
- Reset, then digits 1,2, enter, operand_ready=1 → operand_valid high 2 cycles after enter, operand=12 (4'b1100); digits clear after the handshake.
- Single digit 7, enter, operand_ready held 0 for 5 cycles → operand=7 stable, operand_valid held high; releases on the first ready cycle.
- Digits 1,6, enter → err=1, operand_valid never rises. Then clear_stb → err=0, state EMPTY, d_tens=d_ones=0.
- Digit 4'hB → err=1 immediately, d_ones unchanged. Then digit 3 is ignored until clear_stb.
- Digits 9,1,5 (three strokes) → d_tens=1, d_ones=5; enter → operand=15. Then enter with digit 8 in the same cycle after digit 3 → operand=3.
- Assert rst_n=0 while in HOLD with operand_valid=1 → operand_valid=0, operand=0, err=0 asynchronously, before the next clk edge.
